// File: rtl/drive_seq_pkg.sv
// Shared types for the drive sequencer: state encodings, wheel-direction
// constants and the per-state output decode.
package drive_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FORWARD = 3'd1,
        S_BRAKE   = 3'd2,
        S_REVERSE = 3'd3,
        S_TURN    = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam logic FORWARDS  = 1'b1;
    localparam logic BACKWARDS = 1'b0;

    typedef struct packed {
        logic motor_en;
        logic direction;
        logic dir_l;
        logic dir_r;
    } drive_t;

    // Moore output table; IDLE and FAULT park the motors with the front sensor selected.
    function automatic drive_t drive_for(state_t s);
        drive_t d;
        d = '{1'b0, FORWARDS, FORWARDS, FORWARDS};
        case (s)
            S_FORWARD: d = '{1'b1, FORWARDS,  FORWARDS,  FORWARDS};
            S_BRAKE:   d = '{1'b0, BACKWARDS, FORWARDS,  FORWARDS};
            S_REVERSE: d = '{1'b1, BACKWARDS, BACKWARDS, BACKWARDS};
            S_TURN:    d = '{1'b1, FORWARDS,  BACKWARDS, FORWARDS};
            default:   d = '{1'b0, FORWARDS,  FORWARDS,  FORWARDS};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/drive_seq_timer.sv
// State timer: synchronous clear, saturating up-count, and a terminal flag
// raised when the count equals a runtime-selected limit.
module drive_seq_timer #(
    parameter int TIMER_W = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [TIMER_W-1:0] limit,
    output logic [TIMER_W-1:0] value,
    output logic               done
);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (value != '1) begin
            value <= value + TIMER_W'(1);
        end
    end

    assign done = (value == limit);

endmodule

// File: rtl/drive_sequencer.sv
// Bump-and-turn drive sequencer (FORWARD/BRAKE/REVERSE/TURN) with registered outputs.
// Optional retry limit with FAULT state: define DRIVE_SEQ_RETRY_LIMIT_EN.
module drive_sequencer
    import drive_seq_pkg::*;
#(
    parameter int STOP_CYCLES    = 50_000,
    parameter int REVERSE_CYCLES = 25_000_000,
    parameter int TURN_CYCLES    = 12_500_000,
    parameter int TIMER_W        = 26,
    parameter int MAX_RETRIES    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       halt,
    input  logic       col_ok,
    output logic       direction,
    output logic       motor_en,
    output logic       motor_dir_l,
    output logic       motor_dir_r,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state_dbg
);

    localparam logic [TIMER_W-1:0] STOP_LAST = TIMER_W'(STOP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] STOP_MIN  = TIMER_W'(STOP_CYCLES);
    localparam logic [TIMER_W-1:0] REV_LAST  = TIMER_W'(REVERSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TURN_LAST = TIMER_W'(TURN_CYCLES - 1);

    if (STOP_CYCLES < 1 || REVERSE_CYCLES < 1 || TURN_CYCLES < 1 || MAX_RETRIES < 1 ||
        (longint'(STOP_CYCLES)    >> TIMER_W) != 0 ||
        (longint'(REVERSE_CYCLES) >> TIMER_W) != 0 ||
        (longint'(TURN_CYCLES)    >> TIMER_W) != 0) begin : g_bad_params
        $error("drive_sequencer: cycle counts must satisfy 1 <= N < 2**TIMER_W");
    end

    state_t             state;
    state_t             next_state;
    drive_t             drive_q;
    logic               busy_q;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] limit;
    logic               timer_done;
    logic               retry_hit;

    // FORWARD shares the TURN limit: a full TURN_CYCLES of clear driving forgives past retries.
    always_comb begin
        case (state)
            S_BRAKE:   limit = STOP_LAST;
            S_REVERSE: limit = REV_LAST;
            default:   limit = TURN_LAST;
        endcase
    end

    drive_seq_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (next_state != state),
        .limit (limit),
        .value (timer),
        .done  (timer_done)
    );

`ifdef DRIVE_SEQ_RETRY_LIMIT_EN
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    logic [RETRY_W-1:0] retries;
    logic [RETRY_W-1:0] retry_base;
    logic [RETRY_W-1:0] retry_inc;
    logic               fault_q;

    assign retry_base = (state == S_FORWARD && timer_done) ? '0 : retries;
    assign retry_inc  = retry_base + RETRY_W'(1);
    assign retry_hit  = (retry_inc == RETRY_W'(MAX_RETRIES));

    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) begin
            retries <= '0;
        end else if (state == S_FORWARD && !halt) begin
            if (!col_ok)         retries <= retry_inc;
            else if (timer_done) retries <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= (next_state == S_FAULT);
    end

    assign fault = fault_q;
`else
    assign retry_hit = 1'b0;
    assign fault     = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = S_FORWARD;
            S_FORWARD: if (!col_ok) next_state = retry_hit ? S_FAULT : S_BRAKE;
            S_BRAKE:   if (timer_done) next_state = S_REVERSE;
            S_REVERSE: if (timer_done || (!col_ok && timer >= STOP_MIN)) next_state = S_TURN;
            S_TURN:    if (timer_done) next_state = S_FORWARD;
            S_FAULT:   next_state = S_FAULT;
            default:   next_state = S_IDLE;
        endcase
        if (halt) next_state = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            drive_q <= drive_for(S_IDLE);
            busy_q  <= 1'b0;
        end else begin
            state   <= next_state;
            drive_q <= drive_for(next_state);
            busy_q  <= (next_state != S_IDLE);
        end
    end

    assign motor_en    = drive_q.motor_en;
    assign direction   = drive_q.direction;
    assign motor_dir_l = drive_q.dir_l;
    assign motor_dir_r = drive_q.dir_r;
    assign busy        = busy_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_drive_sequencer.sv
// Self-checking bench for drive_sequencer: directed vector table, a halt-in-TURN
// sequence, and randomized stimulus against a cycle-count reference model.
module tb_drive_sequencer;
    import drive_seq_pkg::*;

    localparam int STOP = 4;
    localparam int REV  = 10;
    localparam int TURN = 6;
    localparam int MAXR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       halt = 1'b0;
    logic       col_ok = 1'b1;
    logic       direction, motor_en, motor_dir_l, motor_dir_r, busy, fault;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    drive_sequencer #(
        .STOP_CYCLES(STOP), .REVERSE_CYCLES(REV), .TURN_CYCLES(TURN),
        .TIMER_W(8), .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .col_ok(col_ok),
        .direction(direction), .motor_en(motor_en), .motor_dir_l(motor_dir_l),
        .motor_dir_r(motor_dir_r), .busy(busy), .fault(fault), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic   rst;
        logic   start;
        logic   halt;
        logic   col_ok;
        state_t exp;
        string  name;
    } vec_t;

    vec_t vecs[$];

    // {state_dbg, motor_en, direction, dir_l, dir_r, busy, fault}
    function automatic logic [8:0] exp_vec(state_t p);
        logic [3:0] b;
        case (p)
            S_FORWARD: b = 4'b1111;
            S_BRAKE:   b = 4'b0011;
            S_REVERSE: b = 4'b1000;
            S_TURN:    b = 4'b1101;
            default:   b = 4'b0111;
        endcase
        return {p, b, p != S_IDLE, p == S_FAULT};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {state_dbg, motor_en, direction, motor_dir_l, motor_dir_r, busy, fault};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic s, input logic h, input logic c,
                                input state_t e, input int n, input string name);
        for (int i = 0; i < n; i++) vecs.push_back('{r, s, h, c, e, name});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: phase plus cycles spent in it, retries as a plain count.
    state_t m_state = S_IDLE;
    int     m_age = 0;
    int     m_retries = 0;

    function automatic void model_step(input logic r, input logic s, input logic h, input logic c);
        state_t nxt = m_state;
        int     base;
        if (r) begin
            m_state = S_IDLE; m_age = 0; m_retries = 0;
            return;
        end
        case (m_state)
            S_IDLE: begin
                m_retries = 0;
                if (s) nxt = S_FORWARD;
            end
            S_FORWARD: if (!c) begin
                base = (m_age >= TURN - 1) ? 0 : m_retries;
                nxt  = S_BRAKE;
`ifdef DRIVE_SEQ_RETRY_LIMIT_EN
                if (base + 1 == MAXR) nxt = S_FAULT;
`endif
                if (!h) m_retries = base + 1;
            end
            S_BRAKE:   if (m_age == STOP - 1) nxt = S_REVERSE;
            S_REVERSE: if (m_age == REV - 1 || (!c && m_age >= STOP)) nxt = S_TURN;
            S_TURN:    if (m_age == TURN - 1) nxt = S_FORWARD;
            default:   nxt = m_state;
        endcase
        if (h) nxt = S_IDLE;
        m_age   = (nxt != m_state) ? 0 : m_age + 1;
        m_state = nxt;
    endfunction

    initial begin
        logic found;

        // Reset, start, full bump-and-turn cycle
        add(1, 0, 0, 1, S_IDLE,    2,  "reset");
        add(0, 0, 0, 1, S_IDLE,    1,  "idle_hold");
        add(0, 1, 0, 1, S_FORWARD, 1,  "start");
        add(0, 1, 0, 1, S_FORWARD, 1,  "start_ignored_fwd");
        add(0, 0, 0, 1, S_FORWARD, 1,  "forward");
        add(0, 0, 0, 0, S_BRAKE,   4,  "brake_4");
        add(0, 0, 0, 1, S_REVERSE, 10, "reverse_10");
        add(0, 0, 0, 1, S_TURN,    1,  "turn_enter");
        add(0, 0, 0, 0, S_TURN,    5,  "turn_ignores_col");
        add(0, 0, 0, 0, S_FORWARD, 1,  "turn_exit");
        // Long forward run, then early REVERSE exit
        add(0, 0, 0, 1, S_FORWARD, 6,  "forward_long");
        add(0, 0, 0, 0, S_BRAKE,   1,  "collide2");
        add(0, 0, 0, 1, S_BRAKE,   3,  "brake2");
        add(0, 0, 0, 1, S_REVERSE, 3,  "reverse2");
        add(0, 0, 0, 0, S_REVERSE, 1,  "rev_col_t2_ignored");
        add(0, 0, 0, 1, S_REVERSE, 2,  "reverse2_more");
        add(0, 0, 0, 0, S_TURN,    1,  "rev_col_t5_exit");
        add(0, 0, 0, 1, S_TURN,    5,  "turn2");
        add(0, 0, 0, 1, S_FORWARD, 1,  "turn2_exit");
        // Quick second collision: FAULT with the retry limit, BRAKE without
        add(0, 0, 0, 1, S_FORWARD, 2,  "forward_short");
`ifdef DRIVE_SEQ_RETRY_LIMIT_EN
        add(0, 0, 0, 0, S_FAULT,   1,  "retry_fault");
        add(0, 1, 0, 1, S_FAULT,   3,  "fault_start_ignored");
`else
        add(0, 0, 0, 0, S_BRAKE,   1,  "no_retry_limit");
        add(0, 1, 0, 1, S_BRAKE,   2,  "brake_start_ignored");
`endif
        add(0, 0, 1, 1, S_IDLE,    1,  "halt_exit");
        add(0, 1, 1, 1, S_IDLE,    2,  "start_and_halt");
        add(0, 1, 0, 1, S_FORWARD, 1,  "restart");
        // Reset mid-REVERSE beats halt and start
        add(0, 0, 0, 0, S_BRAKE,   1,  "collide3");
        add(0, 0, 0, 1, S_BRAKE,   3,  "brake3");
        add(0, 0, 0, 1, S_REVERSE, 8,  "reverse3");
        add(1, 1, 1, 1, S_IDLE,    1,  "rst_mid_reverse");
        add(0, 0, 0, 1, S_IDLE,    1,  "post_rst_idle");
        add(0, 1, 0, 1, S_FORWARD, 1,  "post_rst_start");

        foreach (vecs[i]) begin
            rst = vecs[i].rst; start = vecs[i].start;
            halt = vecs[i].halt; col_ok = vecs[i].col_ok;
            step();
            check(vecs[i].name, dut_vec(), exp_vec(vecs[i].exp));
        end

        // Halt part-way through TURN
        rst = 0; start = 0; halt = 0; col_ok = 0;
        step();
        check("halt_seq_brake", dut_vec(), exp_vec(S_BRAKE));
        col_ok = 1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (state_dbg == S_TURN) found = 1'b1;
        end
        check("reach_turn", {8'b0, found}, 9'd1);
        step();
        halt = 1;
        step();
        check("halt_in_turn", dut_vec(), exp_vec(S_IDLE));
        halt = 0;

        // Randomized run against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst    = (cyc == 0) || ($urandom_range(0, 299) == 0);
            halt   = ($urandom_range(0, 79) == 0);
            start  = ($urandom_range(0, 2) == 0);
            col_ok = ($urandom_range(0, 5) != 0);
            model_step(rst, start, halt, col_ok);
            step();
            check($sformatf("random_c%0d", cyc), dut_vec(), exp_vec(m_state));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
